// File: rtl/dmem_responder.sv
// Word-addressed data memory answering CPU load/store requests over a req/ready
// handshake, with WAIT_CYCLES wait states before each access commits.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] data_in,
    output logic        ready,
    output logic [31:0] data_out,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] data_out_q, data_out_d;

    // Memory has no reset: contents survive rst_n.
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          bad;
    logic          commit;

    assign idx    = adr_q[AW+1:2];
    assign bad    = (adr_q[1:0] != 2'b00) || (adr_q[31:AW+2] != '0);
    assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        data_out_d = data_out_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    adr_d   = adr;
                    wdata_d = data_in;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (commit) begin
                    ready_d    = 1'b1;
                    err_d      = bad;
                    data_out_d = (bad || we_q) ? 32'd0 : mem[idx];
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            adr_q      <= 32'd0;
            wdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    // A reset mid-WAIT forces S_IDLE, so commit stays low and the store is dropped.
    always_ff @(posedge clk) begin
        if (commit && we_q && !bad)
            mem[idx] <= wdata_q;
    end

    assign ready    = ready_q;
    assign err      = err_q;
    assign data_out = data_out_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses from an
// address-map model, a negedge monitor pops and checks them on every ready pulse.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WC    = 3;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [31:0] adr, data_in;
    logic        ready, err, busy;
    logic [31:0] data_out;

    logic        req0, we0;
    logic [31:0] adr0, din0;
    logic        ready0, err0, busy0;
    logic [31:0] dout0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc_e = -1;
    exp_t q[$];
    logic [31:0] ref_mem [int];
    logic  m_eb;
    exp_t  m_e;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adr(adr), .data_in(data_in),
        .ready(ready), .data_out(data_out), .err(err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .adr(adr0), .data_in(din0),
        .ready(ready0), .data_out(dout0), .err(err0), .busy(busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy window from the last accept edge, and one queued response per ready.
    always @(negedge clk) begin
        if (rst_n) begin
            m_eb = (acc_e >= 0) && (cyc >= acc_e) && (cyc <= acc_e + WC + 1);
            chk("busy", 32'(busy), 32'(m_eb));
            if (ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_ready", 32'(ready), 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(m_e.due));
                    chk("err", 32'(err), 32'(m_e.err));
                    if (m_e.chk) chk("data_out", data_out, m_e.data);
                end
            end else begin
                chk("err_without_ready", 32'(err), 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic bad;
        int   wi;
        wait_idle();
        bad = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        wi  = int'(a >> 2);
        e.due = cyc + WC + 2;
        e.err = bad;
        e.chk = 1'b1;
        e.data = 32'd0;
        if (!bad && w) ref_mem[wi] = d;
        else if (!bad && !w) begin
            if (ref_mem.exists(wi)) e.data = ref_mem[wi];
            else e.chk = 1'b0;
        end
        q.push_back(e);
        acc_e = cyc + 1;
        req = 1'b1; we = w; adr = a; data_in = d;
        // Inputs are garbage from the accept onwards, including req during RESP.
        for (int i = 0; i < WC + 2; i++) begin
            @(negedge clk);
            req = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            adr = $urandom;
            data_in = $urandom;
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic abort_store();
        wait_idle();
        acc_e = cyc + 1;
        req = 1'b1; we = 1'b1; adr = 32'h4; data_in = 32'hAAAA5555;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        acc_e = -1;
        #1;
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data_out", data_out, 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Zero-wait instance: req held high, 4 stores then 4 loads back-to-back.
    task automatic run_w0();
        logic [31:0] vals [4];
        logic [31:0] expv;
        int last = -1;
        int n;
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        we0 = 1'b1; adr0 = 32'h0; din0 = vals[0]; req0 = 1'b1;
        for (int op = 0; op < 8; op++) begin
            n = 0;
            @(negedge clk);
            while (!ready0 && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) begin
                chk("w0_timeout", 32'(ready0), 32'd1);
                break;
            end
            expv = (op < 4) ? 32'd0 : vals[op-4];
            chk("w0_data_out", dout0, expv);
            chk("w0_err", 32'(err0), 32'd0);
            if (last >= 0) chk("w0_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            if (op == 7) req0 = 1'b0;
            else begin
                we0  = (op + 1 < 4);
                adr0 = 32'(((op + 1) % 4) * 4);
                din0 = (op + 1 < 4) ? vals[op+1] : $urandom;
            end
            @(negedge clk);
            chk("w0_busy_gap", {30'd0, busy0, ready0}, 32'd0);
        end
    endtask

    initial begin
        int r, n;
        logic [31:0] a;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; adr = 32'd0; data_in = 32'd0;
        req0 = 1'b0; we0 = 1'b0; adr0 = 32'd0; din0 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0);
        access(1'b1, 32'h0, 32'hCAFEF00D);
        access(1'b1, 32'h400, 32'h55AA55AA);
        access(1'b0, 32'h0, 32'h0);
        access(1'b0, 32'h6, 32'h0);
        access(1'b0, 32'h400, 32'h0);
        access(1'b1, 32'h20, 32'h12345678);
        access(1'b0, 32'h20, 32'h0);
        access(1'b1, 32'h4, 32'h11112222);
        access(1'b0, 32'h4, 32'h0);
        abort_store();
        access(1'b0, 32'h4, 32'h0);
        access(1'b1, 32'h3FC, 32'h0BADC0DE);
        access(1'b0, 32'h3FC, 32'h0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 6) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             a = $urandom | 32'h400;
            access(1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while (q.size() > 0 && n < 50) begin @(negedge clk); n++; end
        if (q.size() > 0) chk("pending_responses", 32'(q.size()), 32'd0);

        run_w0();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
